// File: rtl/snake_pkg.sv
// ============================================================================
// snake_pkg: playfield geometry, placer state encoding and default LFSR seed.
// Revision: 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

  localparam int COORD_W   = 4;
  localparam int COORD_MIN = 1;
  localparam int COORD_MAX = 14;

  localparam logic [8:0] LFSR_SEED = 9'd132;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW_X = 2'd1,
    DRAW_Y = 2'd2,
    QUERY  = 2'd3
  } placer_state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr9.sv
// ============================================================================
// lfsr9: free-running 9-bit Galois LFSR, shared by all randomness consumers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr9 #(
  parameter logic [8:0] SEED = 9'd132
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] state
);

  logic [8:0] state_next;

  // Feedback from the top bit is folded into taps 4, 5 and 6.
  always_comb begin
    state_next    = {state[7:0], state[8]};
    state_next[4] = state[3] ^ state[8];
    state_next[5] = state[4] ^ state[8];
    state_next[6] = state[5] ^ state[8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/food_placer.sv
// ============================================================================
// food_placer: draws random X/Y candidates, checks occupancy, publishes food.
// Revision: 1.0
// ============================================================================
`default_nettype none

module food_placer #(
  parameter int         COORD_W   = snake_pkg::COORD_W,
  parameter int         COORD_MIN = snake_pkg::COORD_MIN,
  parameter int         COORD_MAX = snake_pkg::COORD_MAX,
  parameter int         MAX_TRIES = 15,
  parameter logic [8:0] SEED      = snake_pkg::LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_req,
  output logic               occ_query_valid,
  output logic [COORD_W-1:0] occ_query_x,
  output logic [COORD_W-1:0] occ_query_y,
  input  logic               occ_resp_valid,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               fail
);

  import snake_pkg::*;

  localparam logic [8:0]         SPAN      = 9'(COORD_MAX - COORD_MIN + 1);
  localparam logic [8:0]         BASE      = 9'(COORD_MIN);
  localparam logic [7:0]         TRY_LIMIT = 8'(MAX_TRIES);
  localparam logic [COORD_W-1:0] COORD_RST = COORD_W'(COORD_MIN);

  placer_state_t      state;
  placer_state_t      state_next;
  logic [8:0]         lfsr_state;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic [7:0]         tries;
  logic [7:0]         tries_inc;
  logic               last_try;
  logic [COORD_W-1:0] mapped;

  lfsr9 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  // Modulo is taken on the full 9-bit value so the result never leaves the legal range.
  function automatic logic [COORD_W-1:0] map_coord(input logic [8:0] s);
    logic [8:0] m;
    m = (s % SPAN) + BASE;
    return m[COORD_W-1:0];
  endfunction

  assign mapped    = map_coord(lfsr_state);
  assign tries_inc = tries + 8'd1;
  assign last_try  = (tries_inc == TRY_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (spawn_req) state_next = DRAW_X;
      DRAW_X:  state_next = DRAW_Y;
      DRAW_Y:  state_next = QUERY;
      QUERY: begin
        if (occ_resp_valid) begin
          if (!occ_hit || last_try) state_next = IDLE;
          else                      state_next = DRAW_X;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != IDLE);
    occ_query_valid = (state == QUERY);
    occ_query_x     = cand_x;
    occ_query_y     = cand_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_x     <= COORD_RST;
      cand_y     <= COORD_RST;
      food_x     <= COORD_RST;
      food_y     <= COORD_RST;
      food_valid <= 1'b0;
      tries      <= 8'd0;
      fail       <= 1'b0;
    end else begin
      fail <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn_req) begin
            food_valid <= 1'b0;
            tries      <= 8'd0;
          end
        end
        DRAW_X: cand_x <= mapped;
        DRAW_Y: cand_y <= mapped;
        QUERY: begin
          if (occ_resp_valid) begin
            if (!occ_hit) begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
            end else begin
              tries <= tries_inc;
              if (last_try) fail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_food_placer.sv
// ============================================================================
// tb_food_placer: directed checks of placement, retries, give-up and reset abort.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_food_placer;

  logic       clk;
  logic       rst;
  logic       spawn_req;
  logic       occ_query_valid;
  logic [3:0] occ_query_x;
  logic [3:0] occ_query_y;
  logic       occ_resp_valid;
  logic       occ_hit;
  logic [3:0] food_x;
  logic [3:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       fail;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] m_lfsr;
  logic [3:0] last_x;
  logic [3:0] last_y;

  food_placer dut (
    .clk             (clk),
    .rst             (rst),
    .spawn_req       (spawn_req),
    .occ_query_valid (occ_query_valid),
    .occ_query_x     (occ_query_x),
    .occ_query_y     (occ_query_y),
    .occ_resp_valid  (occ_resp_valid),
    .occ_hit         (occ_hit),
    .food_x          (food_x),
    .food_y          (food_y),
    .food_valid      (food_valid),
    .busy            (busy),
    .fail            (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR written in mask form: shift left, XOR taps when the top bit falls out.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 9'd132;
    else     m_lfsr <= {m_lfsr[7:0], 1'b0} ^ (m_lfsr[8] ? 9'h071 : 9'h000);
  end

  function automatic logic [3:0] map_c(input logic [8:0] s);
    int v;
    v = (int'(s) % 14) + 1;
    return v[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_spawn();
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
  endtask

  // Entered in DRAW_X; returns at the negedge after the response edge.
  task automatic round(input logic hit, input int delay, input logic poke);
    logic [3:0] ex;
    logic [3:0] ey;
    check("busy_drawx", busy, 1);
    check("qv_drawx", occ_query_valid, 0);
    ex = map_c(m_lfsr);
    @(negedge clk);
    ey = map_c(m_lfsr);
    @(negedge clk);
    check("qv_query", occ_query_valid, 1);
    check("qx", occ_query_x, ex);
    check("qy", occ_query_y, ey);
    check("fv_query", food_valid, 0);
    for (int i = 0; i < delay; i++) begin
      spawn_req = poke;
      @(negedge clk);
      spawn_req = 1'b0;
      check("qv_wait", occ_query_valid, 1);
      check("qx_wait", occ_query_x, ex);
      check("qy_wait", occ_query_y, ey);
    end
    occ_resp_valid = 1'b1;
    occ_hit        = hit;
    spawn_req      = poke;
    @(negedge clk);
    occ_resp_valid = 1'b0;
    occ_hit        = 1'b0;
    spawn_req      = 1'b0;
    last_x = ex;
    last_y = ey;
  endtask

  initial begin
    rst            = 1'b1;
    spawn_req      = 1'b0;
    occ_resp_valid = 1'b0;
    occ_hit        = 1'b0;
    last_x         = 4'd0;
    last_y         = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("lfsr0", dut.u_lfsr.state, 132);
    check("rst_fv", food_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fail", fail, 0);
    check("rst_qv", occ_query_valid, 0);
    check("rst_fx", food_x, 1);
    check("rst_fy", food_y, 1);
    check("rst_qx", occ_query_x, 1);
    check("rst_qy", occ_query_y, 1);
    @(negedge clk);
    check("lfsr1", dut.u_lfsr.state, 264);
    @(negedge clk);
    check("lfsr2", dut.u_lfsr.state, 97);

    // Immediate free cell.
    start_spawn();
    round(1'b0, 0, 1'b0);
    check("s1_fv", food_valid, 1);
    check("s1_fx", food_x, last_x);
    check("s1_fy", food_y, last_y);
    check("s1_fx_rng", (food_x >= 4'd1 && food_x <= 4'd14), 1);
    check("s1_fy_rng", (food_y >= 4'd1 && food_y <= 4'd14), 1);
    check("s1_busy", busy, 0);

    // Two collisions, third candidate wins.
    @(negedge clk);
    start_spawn();
    check("s2_fv_clr", food_valid, 0);
    round(1'b1, 0, 1'b0);
    check("s2_fail_a", fail, 0);
    round(1'b1, 0, 1'b0);
    check("s2_fail_b", fail, 0);
    round(1'b0, 0, 1'b0);
    check("s2_fv", food_valid, 1);
    check("s2_fx", food_x, last_x);
    check("s2_fy", food_y, last_y);
    check("s2_busy", busy, 0);

    // Every candidate collides: give up after 15 queries.
    @(negedge clk);
    start_spawn();
    for (int i = 0; i < 15; i++) begin
      round(1'b1, 0, 1'b0);
      if (i < 14) check("s3_nofail", fail, 0);
    end
    check("s3_fail", fail, 1);
    check("s3_fv", food_valid, 0);
    check("s3_busy", busy, 0);
    @(negedge clk);
    check("s3_fail_pulse", fail, 0);

    // Slow responder, spawn pokes while busy and on the completion cycle.
    start_spawn();
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    check("s4_busy_dy", busy, 1);
    check("s4_qv_dy", occ_query_valid, 0);
    @(negedge clk);
    check("s4_qv_q", occ_query_valid, 1);
    // Enter the task model one phase later: restart placement from scratch.
    occ_resp_valid = 1'b1;
    occ_hit        = 1'b0;
    @(negedge clk);
    occ_resp_valid = 1'b0;
    check("s4_first_fv", food_valid, 1);
    check("s4_first_busy", busy, 0);
    start_spawn();
    round(1'b0, 5, 1'b1);
    check("s4_fv", food_valid, 1);
    check("s4_fx", food_x, last_x);
    check("s4_fy", food_y, last_y);
    check("s4_busy", busy, 0);
    @(negedge clk);
    check("s4_busy_after", busy, 0);
    occ_resp_valid = 1'b1;
    occ_hit        = 1'b1;
    @(negedge clk);
    occ_resp_valid = 1'b0;
    occ_hit        = 1'b0;
    check("stray_fail", fail, 0);
    check("stray_busy", busy, 0);
    check("stray_fv", food_valid, 1);
    check("stray_fx", food_x, last_x);
    check("stray_fy", food_y, last_y);

    // Reset in QUERY aborts without a fail pulse.
    start_spawn();
    @(negedge clk);
    @(negedge clk);
    check("s5_qv", occ_query_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("s5_busy", busy, 0);
    check("s5_qv_rst", occ_query_valid, 0);
    check("s5_fv", food_valid, 0);
    check("s5_fail", fail, 0);
    check("s5_qx", occ_query_x, 1);
    check("s5_fx", food_x, 1);
    @(negedge clk);
    rst = 1'b0;
    check("s5_lfsr", dut.u_lfsr.state, 132);
    for (int i = 0; i < 3; i++) begin
      check("s5_nofail", fail, 0);
      @(negedge clk);
    end
    start_spawn();
    round(1'b0, 1, 1'b0);
    check("s6_fv", food_valid, 1);
    check("s6_fx", food_x, last_x);
    check("s6_fy", food_y, last_y);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
